// File: rtl/text_renderer.sv
// Character-cell text renderer: VGA timing -> text RAM -> font ROM -> pixel, five register stages.
// Optional blinking underline cursor enabled by defining TEXT_RENDERER_CURSOR_EN.
module text_renderer #(
    parameter int COLS = 80,
    parameter int ROWS = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  i_hcount,
    input  logic [9:0]  i_vcount,
    input  logic        i_hsync,
    input  logic        i_vsync,
    input  logic        i_active,
    output logic [11:0] o_text_addr,
    input  logic [7:0]  i_text_data,
    output logic [11:0] o_font_addr,
    input  logic [7:0]  i_font_data,
    input  logic [6:0]  i_cursor_col,
    input  logic [4:0]  i_cursor_row,
    output logic        o_pixel,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_active
);

    localparam logic [11:0] COLS_W = 12'(COLS);
    localparam logic [11:0] ROWS_W = 12'(ROWS);

    typedef struct packed {
        logic act;
        logic hs;
        logic vs;
        logic cur;
    } ctl_t;

    logic [6:0]  col;
    logic [5:0]  row;
    logic [3:0]  glyph_row;
    logic [11:0] col_w;
    logic [11:0] row_w;
    logic [11:0] addr_c;
    logic        in_range;
    logic        cur_hit;

    logic [3:0]  grow1, grow2;
    logic [2:0]  bit1, bit2, bit3, bit4;
    ctl_t        ctl1, ctl2, ctl3, ctl4;

    assign col       = i_hcount[9:3];
    assign row       = i_vcount[9:4];
    assign glyph_row = i_vcount[3:0];
    assign col_w     = 12'(col);
    assign row_w     = 12'(row);
    assign in_range  = (col_w < COLS_W) && (row_w < ROWS_W);

    // The default width of 80 avoids a multiplier: 80*row = 64*row + 16*row.
    always_comb begin
        addr_c = '0;
        if (COLS == 80)
            addr_c = (row_w << 6) + (row_w << 4) + col_w;
        else
            addr_c = row_w * COLS_W + col_w;
    end

`ifdef TEXT_RENDERER_CURSOR_EN
    logic [5:0] frame_cnt;
    logic       vsync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
            vsync_q   <= 1'b0;
        end else begin
            vsync_q <= i_vsync;
            if (i_vsync && !vsync_q)
                frame_cnt <= frame_cnt + 6'd1;
        end
    end

    // Underline occupies glyph rows 14 and 15 of the cursor cell during the visible blink phase.
    assign cur_hit = frame_cnt[5] && (col == i_cursor_col) && (row == {1'b0, i_cursor_row})
                     && (glyph_row[3:1] == 3'b111);
`else
    logic unused_cursor;
    assign unused_cursor = ^{i_cursor_col, i_cursor_row};
    assign cur_hit       = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_text_addr <= '0;
            o_font_addr <= '0;
            o_pixel     <= 1'b0;
            o_hsync     <= 1'b0;
            o_vsync     <= 1'b0;
            o_active    <= 1'b0;
            grow1       <= '0;
            grow2       <= '0;
            bit1        <= '0;
            bit2        <= '0;
            bit3        <= '0;
            bit4        <= '0;
            ctl1        <= '0;
            ctl2        <= '0;
            ctl3        <= '0;
            ctl4        <= '0;
        end else begin
            o_text_addr <= (i_active && in_range) ? addr_c : 12'd0;
            grow1       <= glyph_row;
            bit1        <= i_hcount[2:0];
            ctl1        <= {i_active, i_hsync, i_vsync, cur_hit};

            grow2       <= grow1;
            bit2        <= bit1;
            ctl2        <= ctl1;

            o_font_addr <= {i_text_data, grow2};
            bit3        <= bit2;
            ctl3        <= ctl2;

            bit4        <= bit3;
            ctl4        <= ctl3;

            o_pixel     <= ctl4.act & (i_font_data[3'd7 - bit4] | ctl4.cur);
            o_hsync     <= ctl4.hs;
            o_vsync     <= ctl4.vs;
            o_active    <= ctl4.act;
        end
    end

endmodule
